// File: rtl/nmos_phase_gen.sv
// Two-phase non-overlapping clock-enable generator: DIV main_clk slots per machine cycle.
// Optional single-step input enabled by defining NMOS_PHASE_STEP_EN.
module nmos_phase_gen #(
    parameter int unsigned DIV = 4,
    parameter int unsigned CW  = 16
) (
    input  logic                    main_clk,
    input  logic                    rst_n,
    input  logic                    RUN,
`ifdef NMOS_PHASE_STEP_EN
    input  logic                    STEP,
`endif
    output logic                    PHI1,
    output logic                    PHI2,
    output logic                    PHI1_P,
    output logic                    PHI2_P,
    output logic [$clog2(DIV)-1:0]  SLOT,
    output logic [CW-1:0]           CYC_CNT,
    output logic                    HALTED
);

    localparam int unsigned SW = $clog2(DIV);

    localparam logic [SW-1:0] Phi1Last  = SW'(DIV / 2 - 2);
    localparam logic [SW-1:0] Phi2First = SW'(DIV / 2);
    localparam logic [SW-1:0] Phi2Last  = SW'(DIV - 2);
    localparam logic [SW-1:0] SlotLast  = SW'(DIV - 1);

    if ((DIV % 2) != 0 || DIV < 4) begin : g_bad_div
        $error("nmos_phase_gen: DIV must be even and >= 4");
    end

    logic [SW-1:0] slot_q, slot_d;
    logic          running_q, running_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic          start;

`ifdef NMOS_PHASE_STEP_EN
    logic step_q;

    // Only a rising STEP edge starts a cycle, so a held STEP yields one step.
    assign start = RUN | (STEP & ~step_q);

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= STEP;
        end
    end
`else
    assign start = RUN;
`endif

    always_comb begin
        slot_d    = slot_q;
        running_d = running_q;
        cyc_cnt_d = cyc_cnt_q;
        if (!running_q) begin
            slot_d    = '0;
            running_d = start;
        end else if (slot_q == SlotLast) begin
            // Halt decisions are taken only here, so a phase is never truncated.
            slot_d    = '0;
            cyc_cnt_d = cyc_cnt_q + CW'(1);
            running_d = RUN;
        end else begin
            slot_d = slot_q + SW'(1);
        end
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= '0;
            running_q <= 1'b0;
            cyc_cnt_q <= '0;
        end else begin
            slot_q    <= slot_d;
            running_q <= running_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign PHI1    = running_q && (slot_q <= Phi1Last);
    assign PHI2    = running_q && (slot_q >= Phi2First) && (slot_q <= Phi2Last);
    assign PHI1_P  = running_q && (slot_q == '0);
    assign PHI2_P  = running_q && (slot_q == Phi2First);
    assign SLOT    = slot_q;
    assign CYC_CNT = cyc_cnt_q;
    assign HALTED  = ~running_q;

endmodule

// File: tb/tb_nmos_phase_gen.sv
// Directed bench for nmos_phase_gen with DIV=4, CW=4 (small counter to exercise wrap).
module tb_nmos_phase_gen;

    logic       main_clk;
    logic       rst_n;
    logic       RUN;
`ifdef NMOS_PHASE_STEP_EN
    logic       STEP;
`endif
    logic       PHI1, PHI2, PHI1_P, PHI2_P, HALTED;
    logic [1:0] SLOT;
    logic [3:0] CYC_CNT;

    int n_cmp = 0;
    int n_bad = 0;

    nmos_phase_gen #(.DIV(4), .CW(4)) dut (
        .main_clk (main_clk),
        .rst_n    (rst_n),
        .RUN      (RUN),
`ifdef NMOS_PHASE_STEP_EN
        .STEP     (STEP),
`endif
        .PHI1     (PHI1),
        .PHI2     (PHI2),
        .PHI1_P   (PHI1_P),
        .PHI2_P   (PHI2_P),
        .SLOT     (SLOT),
        .CYC_CNT  (CYC_CNT),
        .HALTED   (HALTED)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        RUN   = 1'b0;
`ifdef NMOS_PHASE_STEP_EN
        STEP  = 1'b0;
`endif
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RUN   = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({PHI1, PHI2, PHI1_P, PHI2_P, SLOT, HALTED} !== 7'b0000_00_1) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0000001",
                     {PHI1, PHI2, PHI1_P, PHI2_P, SLOT, HALTED});
        end
        n_cmp++;
        if (CYC_CNT !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d want 0", CYC_CNT);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (HALTED !== 1'b1) begin
            n_bad++;
            $display("FAIL release_halted: got %b want 1", HALTED);
        end
        tick();
        n_cmp++;
        if ({PHI1, PHI1_P, PHI2, HALTED} !== 4'b1100) begin
            n_bad++;
            $display("FAIL first_phi1: got %b want 1100", {PHI1, PHI1_P, PHI2, HALTED});
        end
    endtask

    task automatic test_run();
        logic [1:0] s;
        logic [5:0] exp_v;
        do_reset();
        RUN = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            tick();
            s     = 2'(k % 4);
            exp_v = {s == 2'd0, s == 2'd2, s == 2'd0, s == 2'd2, s};
            n_cmp++;
            if ({PHI1, PHI2, PHI1_P, PHI2_P, SLOT} !== exp_v) begin
                n_bad++;
                $display("FAIL run_phase k=%0d: got %b want %b", k,
                         {PHI1, PHI2, PHI1_P, PHI2_P, SLOT}, exp_v);
            end
            n_cmp++;
            if ((PHI1 & PHI2) !== 1'b0) begin
                n_bad++;
                $display("FAIL run_overlap k=%0d: got %b want 0", k, PHI1 & PHI2);
            end
        end
        n_cmp++;
        if (CYC_CNT !== 4'd10) begin
            n_bad++;
            $display("FAIL run_cnt: got %0d want 10", CYC_CNT);
        end
    endtask

    task automatic test_halt();
        do_reset();
        RUN = 1'b1;
        tick();
        tick();
        RUN = 1'b0;
        tick();
        n_cmp++;
        if ({PHI2, PHI2_P, HALTED, SLOT} !== 5'b110_10) begin
            n_bad++;
            $display("FAIL halt_phi2: got %b want 11010", {PHI2, PHI2_P, HALTED, SLOT});
        end
        tick();
        n_cmp++;
        if ({PHI1, PHI2, HALTED, SLOT} !== 5'b000_11) begin
            n_bad++;
            $display("FAIL halt_dead: got %b want 00011", {PHI1, PHI2, HALTED, SLOT});
        end
        tick();
        n_cmp++;
        if ({PHI1, PHI1_P, HALTED, SLOT, CYC_CNT} !== {5'b001_00, 4'd1}) begin
            n_bad++;
            $display("FAIL halt_boundary: got %b want 001000001",
                     {PHI1, PHI1_P, HALTED, SLOT, CYC_CNT});
        end
        tick();
        n_cmp++;
        if ({HALTED, CYC_CNT} !== {1'b1, 4'd1}) begin
            n_bad++;
            $display("FAIL halt_hold: got %b want 10001", {HALTED, CYC_CNT});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        RUN = 1'b1;
        tick();
        for (int k = 1; k <= 68; k++) begin
            tick();
            if (k == 60 || k == 64 || k == 68) begin
                n_cmp++;
                if (CYC_CNT !== 4'((k / 4) % 16)) begin
                    n_bad++;
                    $display("FAIL wrap_cnt k=%0d: got %0d want %0d", k, CYC_CNT, (k / 4) % 16);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        RUN = 1'b1;
        tick();
        repeat (6) tick();
        n_cmp++;
        if ({PHI2, SLOT, CYC_CNT} !== {1'b1, 2'd2, 4'd1}) begin
            n_bad++;
            $display("FAIL areset_pre: got %b want 1100001", {PHI2, SLOT, CYC_CNT});
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({PHI2, SLOT, HALTED, CYC_CNT} !== {1'b0, 2'd0, 1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL areset_post: got %b want 0001 0000", {PHI2, SLOT, HALTED, CYC_CNT});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        RUN = 1'b1;
        tick();
        tick();
        RUN = 1'b0;
        tick();
        RUN = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({PHI1, PHI1_P, HALTED, SLOT, CYC_CNT} !== {5'b110_00, 4'd1}) begin
            n_bad++;
            $display("FAIL b2b_no_gap: got %b want 110000001",
                     {PHI1, PHI1_P, HALTED, SLOT, CYC_CNT});
        end
    endtask

`ifdef NMOS_PHASE_STEP_EN
    task automatic test_step();
        int n1, n2;
        n1 = 0;
        n2 = 0;
        do_reset();
        RUN  = 1'b0;
        STEP = 1'b1;
        repeat (20) begin
            tick();
            if (PHI1_P) n1++;
            if (PHI2_P) n2++;
        end
        STEP = 1'b0;
        n_cmp++;
        if ({n1, n2} !== {32'd1, 32'd1}) begin
            n_bad++;
            $display("FAIL step_pulses: got %0d/%0d want 1/1", n1, n2);
        end
        n_cmp++;
        if ({HALTED, CYC_CNT} !== {1'b1, 4'd1}) begin
            n_bad++;
            $display("FAIL step_end: got %b want 10001", {HALTED, CYC_CNT});
        end
    endtask
`endif

    initial begin
`ifdef NMOS_PHASE_STEP_EN
        STEP = 1'b0;
`endif
        test_reset();
        test_run();
        test_halt();
        test_wrap();
        test_async_reset();
        test_back_to_back();
`ifdef NMOS_PHASE_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
